// File: rtl/pmem_banked.sv
// pmem_banked: banked code/data memory with latency, range and write-protect errors.
// Ports: clock, reset (sync, active-high), select/addr/data_in/memory_type_data/write/code_wp in;
//        data_out, data_ready, error out (all registered).
module pmem_banked #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int CODE_DEPTH     = 32,
  parameter int DATA_DEPTH     = 8,
  parameter int LATENCY        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              select,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              memory_type_data,
  input  logic              write,
  input  logic              code_wp,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              error
);

  localparam int CW = (CODE_DEPTH > 1) ? $clog2(CODE_DEPTH) : 1;
  localparam int DW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  // One extra bit so a depth of exactly 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] CODE_LIM = CODE_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] DATA_LIM = DATA_DEPTH[ADDR_W:0];
  localparam logic [3:0]      LAT      = LATENCY[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  logic [3:0] cnt;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_mtd;
  logic              req_wr;

  logic [DATA_W-1:0] code_mem [CODE_DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_DEPTH];

  logic [CW-1:0]     cidx;
  logic [DW-1:0]     didx;
  logic              in_range;
  logic              acc_fire;
  logic              wr_ok;
  logic              acc_err;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] acc_out;

  assign cidx = req_addr[CW-1:0];
  assign didx = req_addr[DW-1:0];

  // Full-width unsigned compare: no aliasing onto low address bits.
  assign in_range = req_mtd
                  ? ({1'b0, req_addr} < DATA_LIM)
                  : ({1'b0, req_addr} < CODE_LIM);

  // The single access edge of a transaction.
  assign acc_fire = (state == S_WAIT) && select && (cnt == 4'd0);

  // code_wp is looked at live, i.e. on the access edge.
  assign wr_ok = req_wr && in_range && (req_mtd || !code_wp);

  assign acc_err = !in_range || (req_wr && !req_mtd && code_wp);

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      if (req_mtd) rd_word = data_mem[didx];
      else         rd_word = code_mem[cidx];
    end
  end

  assign acc_out = (req_wr || !in_range) ? '0 : rd_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < CODE_DEPTH; i++) code_mem[i] <= '0;
        for (int i = 0; i < DATA_DEPTH; i++) data_mem[i] <= '0;
      end
    end else if (acc_fire && wr_ok) begin
      if (req_mtd) data_mem[didx] <= req_data;
      else         code_mem[cidx] <= req_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_addr   <= '0;
      req_data   <= '0;
      req_mtd    <= 1'b0;
      req_wr     <= 1'b0;
      data_out   <= '0;
      data_ready <= 1'b0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (select) begin
            req_addr <= addr;
            req_data <= data_in;
            req_mtd  <= memory_type_data;
            req_wr   <= write;
            cnt      <= LAT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!select) begin
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            data_out   <= acc_out;
            error      <= acc_err;
            data_ready <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!select) begin
            data_out   <= '0;
            error      <= 1'b0;
            data_ready <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_banked.sv
// tb_pmem_banked: directed self-checking bench for pmem_banked.
// Three instances: defaults, LATENCY=3, LATENCY=2 with CLEAR_ON_RESET=0.
module tb_pmem_banked;

  logic       clock;
  logic       rst [3];
  logic       sel [3];
  logic [7:0] addr;
  logic [7:0] din;
  logic       mtd;
  logic       wr;
  logic       wp;
  logic [7:0] dout [3];
  logic       dr   [3];
  logic       er   [3];

  int n_asrt = 0;
  int n_fail = 0;

  pmem_banked u_a (
    .clock(clock), .reset(rst[0]), .select(sel[0]),
    .addr(addr), .data_in(din), .memory_type_data(mtd),
    .write(wr), .code_wp(wp),
    .data_out(dout[0]), .data_ready(dr[0]), .error(er[0])
  );

  pmem_banked #(.LATENCY(3)) u_b (
    .clock(clock), .reset(rst[1]), .select(sel[1]),
    .addr(addr), .data_in(din), .memory_type_data(mtd),
    .write(wr), .code_wp(wp),
    .data_out(dout[1]), .data_ready(dr[1]), .error(er[1])
  );

  pmem_banked #(.LATENCY(2), .CLEAR_ON_RESET(0)) u_c (
    .clock(clock), .reset(rst[2]), .select(sel[2]),
    .addr(addr), .data_in(din), .memory_type_data(mtd),
    .write(wr), .code_wp(wp),
    .data_out(dout[2]), .data_ready(dr[2]), .error(er[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat(input int i);
    return (i == 1) ? 3 : (i == 2) ? 2 : 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int i, input logic m, input logic w,
                    input logic [7:0] a, input logic [7:0] d);
    mtd = m; wr = w; addr = a; din = d;
    sel[i] = 1'b1;
    repeat (lat(i) + 2) tick();
  endtask

  task automatic stop(input int i, input string tag);
    sel[i] = 1'b0;
    tick();
    chk(tag, {7'd0, dr[i]}, 8'h00);
  endtask

  task automatic rd(input int i, input logic m, input logic [7:0] a,
                    input logic [7:0] exp, input logic e, input string tag);
    go(i, m, 1'b0, a, 8'h00);
    chk({tag, "_rdy"}, {7'd0, dr[i]}, 8'h01);
    chk({tag, "_data"}, dout[i], exp);
    chk({tag, "_err"}, {7'd0, er[i]}, {7'd0, e});
    stop(i, {tag, "_drop"});
  endtask

  task automatic wrt(input int i, input logic m, input logic [7:0] a,
                     input logic [7:0] d, input logic e, input string tag);
    go(i, m, 1'b1, a, d);
    chk({tag, "_rdy"}, {7'd0, dr[i]}, 8'h01);
    chk({tag, "_err"}, {7'd0, er[i]}, {7'd0, e});
    chk({tag, "_data"}, dout[i], 8'h00);
    stop(i, {tag, "_drop"});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      sel[i] = 1'b0;
    end
    addr = '0; din = '0; mtd = 1'b0; wr = 1'b0; wp = 1'b0;
    tick();
    tick();
    chk("rst_rdy", {7'd0, dr[0]}, 8'h00);
    chk("rst_data", dout[0], 8'h00);
    chk("rst_err", {7'd0, er[0]}, 8'h00);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    rd(0, 1'b0, 8'd5, 8'h00, 1'b0, "code5_init");

    // LATENCY 0: ready exactly one cycle after capture
    mtd = 1'b1; wr = 1'b1; addr = 8'd3; din = 8'hA5;
    sel[0] = 1'b1;
    tick();
    chk("l0_cap_rdy", {7'd0, dr[0]}, 8'h00);
    tick();
    chk("l0_acc_rdy", {7'd0, dr[0]}, 8'h01);
    chk("l0_acc_err", {7'd0, er[0]}, 8'h00);
    stop(0, "l0_drop");
    rd(0, 1'b1, 8'd3, 8'hA5, 1'b0, "data3");

    wrt(0, 1'b0, 8'd31, 8'h3C, 1'b0, "wr_code31");
    rd(0, 1'b0, 8'd31, 8'h3C, 1'b0, "code31");

    rd(0, 1'b1, 8'd8, 8'h00, 1'b1, "data8_oor");
    wrt(0, 1'b0, 8'd32, 8'h11, 1'b1, "wr_code32_oor");
    rd(0, 1'b0, 8'd0, 8'h00, 1'b0, "code0");
    rd(0, 1'b1, 8'd255, 8'h00, 1'b1, "data255_oor");

    wrt(0, 1'b0, 8'd1, 8'h5A, 1'b0, "wr_code1");
    wp = 1'b1;
    wrt(0, 1'b0, 8'd1, 8'h77, 1'b1, "wr_code1_wp");
    wrt(0, 1'b1, 8'd2, 8'h66, 1'b0, "wr_data2_wp");
    wp = 1'b0;
    rd(0, 1'b0, 8'd1, 8'h5A, 1'b0, "code1_kept");
    rd(0, 1'b1, 8'd2, 8'h66, 1'b0, "data2");

    // protect raised after capture still blocks the write
    mtd = 1'b0; wr = 1'b1; addr = 8'd2; din = 8'h99;
    sel[0] = 1'b1;
    tick();
    wp = 1'b1;
    tick();
    chk("wp_late_err", {7'd0, er[0]}, 8'h01);
    stop(0, "wp_late_drop");
    wp = 1'b0;
    rd(0, 1'b0, 8'd2, 8'h00, 1'b0, "code2_kept");

    // select held in DONE with churning ports
    go(0, 1'b1, 1'b1, 8'd4, 8'h42);
    for (int k = 0; k < 5; k++) begin
      addr = 8'd5 + 8'(k);
      din  = 8'hF0 + 8'(k);
      tick();
      chk("hold_rdy", {7'd0, dr[0]}, 8'h01);
      chk("hold_err", {7'd0, er[0]}, 8'h00);
      chk("hold_data", dout[0], 8'h00);
    end
    stop(0, "hold_drop");
    rd(0, 1'b1, 8'd4, 8'h42, 1'b0, "data4");
    rd(0, 1'b1, 8'd5, 8'h00, 1'b0, "data5_untouched");
    rd(0, 1'b1, 8'd7, 8'h00, 1'b0, "data7_untouched");

    // CLEAR_ON_RESET=1 zeroes arrays
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    rd(0, 1'b1, 8'd3, 8'h00, 1'b0, "data3_cleared");

    // LATENCY 3 timing
    mtd = 1'b1; wr = 1'b1; addr = 8'd0; din = 8'h81;
    sel[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("l3_wait_rdy", {7'd0, dr[1]}, 8'h00);
    end
    tick();
    chk("l3_rdy", {7'd0, dr[1]}, 8'h01);
    chk("l3_err", {7'd0, er[1]}, 8'h00);
    stop(1, "l3_drop");
    rd(1, 1'b1, 8'd0, 8'h81, 1'b0, "l3_data0");

    // abort at E+2
    mtd = 1'b1; wr = 1'b1; addr = 8'd0; din = 8'h22;
    sel[1] = 1'b1;
    tick();
    tick();
    sel[1] = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_rdy", {7'd0, dr[1]}, 8'h00);
    end
    rd(1, 1'b1, 8'd0, 8'h81, 1'b0, "abort_kept");

    // reset at the would-be access edge, CLEAR_ON_RESET=0
    wrt(2, 1'b1, 8'd1, 8'h6B, 1'b0, "l2_wr");
    mtd = 1'b1; wr = 1'b1; addr = 8'd1; din = 8'hEE;
    sel[2] = 1'b1;
    tick();
    tick();
    tick();
    chk("l2_pre_rdy", {7'd0, dr[2]}, 8'h00);
    rst[2] = 1'b1;
    tick();
    chk("l2_rst_rdy", {7'd0, dr[2]}, 8'h00);
    rst[2] = 1'b0;
    sel[2] = 1'b0;
    tick();
    rd(2, 1'b1, 8'd1, 8'h6B, 1'b0, "l2_retained");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
